// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM access controller.
// Serves aligned word reads/writes one at a time and can sweep all 64 words
// to CLR_VAL. Every output, including ready, comes straight from a flop.
module mem_ctrl #(
  parameter logic [31:0] CLR_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        clr_start,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        clr_done,
  output logic        ram_wea,
  output logic [5:0]  ram_addr,
  output logic [31:0] ram_dina,
  input  logic [31:0] ram_douta
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    CLR  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [5:0]  cnt_r, cnt_s;
  logic        ready_r, ready_s;
  logic        wea_r, wea_s;
  logic [5:0]  raddr_r, raddr_s;
  logic [31:0] dina_r, dina_s;
  logic [31:0] rdata_r, rdata_s;
  logic        rvalid_r, rvalid_s;
  logic        err_r, err_s;
  logic        done_r, done_s;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; clr_start wins over req, misaligned req stays in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr_start) begin
          state_s = CLR;
        end else if (req && (addr[1:0] == 2'b00)) begin
          state_s = we ? WR : RD1;
        end else begin
          state_s = IDLE;
        end
      end
      WR:  state_s = IDLE;
      RD1: state_s = RD2;
      RD2: state_s = IDLE;
      CLR: begin
        if (cnt_r == 6'd63) begin
          state_s = IDLE;
        end else begin
          state_s = CLR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; pulses default low, RAM bus holds.
  always_comb begin
    cnt_s    = cnt_r;
    wea_s    = 1'b0;
    raddr_s  = raddr_r;
    dina_s   = dina_r;
    rdata_s  = rdata_r;
    rvalid_s = 1'b0;
    err_s    = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr_start) begin
          cnt_s   = 6'd0;
          wea_s   = 1'b1;
          raddr_s = 6'd0;
          dina_s  = CLR_VAL;
        end else if (req) begin
          if (addr[1:0] != 2'b00) begin
            err_s = 1'b1;
          end else begin
            raddr_s = addr[7:2];
            if (we) begin
              wea_s  = 1'b1;
              dina_s = wdata;
            end else begin
              wea_s = 1'b0;
            end
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      WR:  wea_s = 1'b0;
      RD1: wea_s = 1'b0;
      RD2: begin
        // RAM output reflects the address presented two edges ago.
        rdata_s  = ram_douta;
        rvalid_s = 1'b1;
      end
      CLR: begin
        // cnt_r is the word being written this cycle; stop after word 63.
        if (cnt_r == 6'd63) begin
          done_s = 1'b1;
          cnt_s  = 6'd0;
        end else begin
          cnt_s   = cnt_r + 6'd1;
          wea_s   = 1'b1;
          raddr_s = cnt_r + 6'd1;
          dina_s  = CLR_VAL;
        end
      end
      default: wea_s = 1'b0;
    endcase
    ready_s = (state_s == IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r  <= 1'b1;
      wea_r    <= 1'b0;
      raddr_r  <= 6'd0;
      dina_r   <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      ready_r  <= ready_s;
      wea_r    <= wea_s;
      raddr_r  <= raddr_s;
      dina_r   <= dina_s;
      rdata_r  <= rdata_s;
      rvalid_r <= rvalid_s;
      err_r    <= err_s;
      done_r   <= done_s;
    end
  end

  assign ready    = ready_r;
  assign ram_wea  = wea_r;
  assign ram_addr = raddr_r;
  assign ram_dina = dina_r;
  assign rdata    = rdata_r;
  assign rvalid   = rvalid_r;
  assign err      = err_r;
  assign clr_done = done_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven and sequence tests for mem_ctrl with a RAM model
// and a read-data scoreboard.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic        clr_start = 1'b0;
  logic        ready, rvalid, err, clr_done, ram_wea;
  logic [31:0] rdata, ram_dina;
  logic [31:0] ram_douta = 32'h0;
  logic [5:0]  ram_addr;

  mem_ctrl #(.CLR_VAL(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clr_start(clr_start), .ready(ready), .rdata(rdata), .rvalid(rvalid),
    .err(err), .clr_done(clr_done), .ram_wea(ram_wea), .ram_addr(ram_addr),
    .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t         sbq[$];
  int          rv_cyc[$];
  logic [31:0] mem [0:63];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wea_cnt = 0;
  int done_cnt = 0;
  int clr_idx = 0;
  logic clr_mon = 1'b0;

  // Synchronous read-first RAM model.
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addr] <= ram_dina;
    ram_douta <= mem[ram_addr];
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: RAM write counting, clear sweep order, scoreboard pop on rvalid.
  always @(negedge clk) begin
    if (ram_wea) begin
      wea_cnt++;
      if (clr_mon) begin
        chk("clr_addr", {26'd0, ram_addr}, clr_idx);
        chk("clr_data", ram_dina, 32'h0000_0000);
        clr_idx++;
      end
    end
    if (clr_done) done_cnt++;
    if (rvalid) begin
      rv_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got rdata %h with empty scoreboard", rdata);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("rdata", rdata, e.data);
        chk("rvalid_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!clr_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clr_done_timeout", {31'd0, clr_done}, 32'd1);
    @(negedge clk);
    chk("clr_done_pulse", {31'd0, clr_done}, 32'd0);
  endtask

  task automatic do_req(input vec_t v);
    sb_t e;
    wait_ready();
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    req = 1'b0;
    if (v.exp_err) begin
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_no_wea", {31'd0, ram_wea}, 32'd0);
      chk("err_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      chk("err_one_cycle", {31'd0, err}, 32'd0);
    end else if (v.we) begin
      chk("wr_wea", {31'd0, ram_wea}, 32'd1);
      chk("wr_addr", {26'd0, ram_addr}, {26'd0, v.addr[7:2]});
      chk("wr_dina", ram_dina, v.wdata);
      chk("wr_busy", {31'd0, ready}, 32'd0);
      @(negedge clk);
      chk("wr_wea_one_cycle", {31'd0, ram_wea}, 32'd0);
      chk("wr_ready_back", {31'd0, ready}, 32'd1);
    end else begin
      chk("rd_busy", {31'd0, ready}, 32'd0);
      chk("rd_no_wea", {31'd0, ram_wea}, 32'd0);
      chk("rd_addr", {26'd0, ram_addr}, {26'd0, v.addr[7:2]});
      e.data = v.exp_rd;
      e.due = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  vec_t tbl[12];

  initial begin
    int w0, d0, n;
    sb_t e;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    tbl[0]  = '{1'b1, 8'h14, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 8'h14, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 8'h06, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{1'b1, 8'h06, 32'hCAFEF00D, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 8'h00, 32'h11111111, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 8'h04, 32'h22222222, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 8'h00, 32'h0,        1'b0, 32'h11111111};
    tbl[7]  = '{1'b0, 8'h04, 32'h0,        1'b0, 32'h22222222};
    tbl[8]  = '{1'b1, 8'hFC, 32'h12345678, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 8'hFC, 32'h0,        1'b0, 32'h12345678};
    tbl[10] = '{1'b1, 8'h03, 32'h55555555, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 8'h14, 32'h0,        1'b0, 32'hDEADBEEF};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_wea", {31'd0, ram_wea}, 32'd0);
    chk("rst_addr", {26'd0, ram_addr}, 32'd0);
    chk("rst_dina", ram_dina, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulses", {29'd0, rvalid, err, clr_done}, 32'd0);

    // Table-driven single accesses.
    for (int i = 0; i < 12; i++) do_req(tbl[i]);
    wait_ready();
    repeat (3) @(negedge clk);
    chk("rdata_held", rdata, 32'hDEADBEEF);

    // Clear sweep after 0xFC was written.
    clr_mon = 1'b1; clr_idx = 0; w0 = wea_cnt; d0 = done_cnt;
    wait_ready();
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    wait_done();
    clr_mon = 1'b0;
    chk("clr_wea_count", wea_cnt - w0, 32'd64);
    chk("clr_words", clr_idx, 32'd64);
    chk("clr_done_count", done_cnt - d0, 32'd1);
    chk("clr_ready", {31'd0, ready}, 32'd1);
    do_req('{1'b0, 8'hFC, 32'h0, 1'b0, 32'h0});
    do_req('{1'b0, 8'h14, 32'h0, 1'b0, 32'h0});

    // clr_start and req in the same IDLE cycle: clear wins, req dropped.
    wait_ready();
    clr_mon = 1'b1; clr_idx = 0; w0 = wea_cnt;
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 32'hAAAA5555; clr_start = 1'b1;
    @(negedge clk);
    req = 1'b0; clr_start = 1'b0;
    chk("prio_busy", {31'd0, ready}, 32'd0);
    wait_done();
    clr_mon = 1'b0;
    chk("prio_wea_count", wea_cnt - w0, 32'd64);
    repeat (3) @(negedge clk);
    chk("prio_no_queue", wea_cnt - w0, 32'd64);
    do_req('{1'b0, 8'h20, 32'h0, 1'b0, 32'h0});

    // Reset in the middle of a clear sweep.
    wait_ready();
    clr_mon = 1'b1; clr_idx = 0; d0 = done_cnt;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (!(ram_wea && ram_addr == 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach20", {26'd0, ram_addr}, 32'd20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr_mon = 1'b0;
    chk("abort_wea", {31'd0, ram_wea}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    w0 = wea_cnt;
    repeat (70) @(negedge clk);
    chk("abort_no_writes", wea_cnt - w0, 32'd0);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    // Held req with alternating reads: one acceptance per IDLE cycle.
    do_req('{1'b1, 8'h00, 32'hA5A5A5A5, 1'b0, 32'h0});
    do_req('{1'b1, 8'h04, 32'h5A5A5A5A, 1'b0, 32'h0});
    rv_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      req = 1'b1; we = 1'b0;
      addr = (i % 2 == 1) ? 8'h04 : 8'h00;
      @(negedge clk);
      chk("b2b_accept", {31'd0, ready}, 32'd0);
      e.data = (i % 2 == 1) ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      e.due = cyc + 2;
      sbq.push_back(e);
    end
    req = 1'b0;
    wait_ready();
    repeat (4) @(negedge clk);
    chk("b2b_rvalid_count", rv_cyc.size(), 32'd4);
    if (rv_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_spacing", rv_cyc[i] - rv_cyc[i-1], 32'd3);
    end
    chk("sb_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter CLR_VAL, default 32'h0000_0000: word value written to every location during a clear sweep.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req  input  1  access request, sampled only while ready=1.
REQ-005 we  input  1  access type: 1=write, 0=read; qualified by req.
REQ-006 addr  input  8  byte address; [7:2] selects the word, [1:0] must be 2'b00.
REQ-007 wdata  input  32  write data; qualified by req&we.
REQ-008 clr_start  input  1  starts a clear sweep of all 64 words; sampled only while ready=1.
REQ-009 ready  output  1  controller idle and able to accept req or clr_start.
REQ-010 rdata  output  32  read data, held until the next completed read.
REQ-011 rvalid  output  1  one-cycle pulse; rdata is valid.
REQ-012 err  output  1  one-cycle pulse; misaligned request rejected.
REQ-013 clr_done  output  1  one-cycle pulse; clear sweep finished.
REQ-014 ram_wea  output  1  RAM write enable, registered.
REQ-015 ram_addr  output  6  RAM word address [7:2], registered.
REQ-016 ram_dina  output  32  RAM write data, registered.
REQ-017 ram_douta  input  32  RAM read data; valid one clock edge after ram_addr is sampled.

Function
REQ-018 FSM states SHALL be IDLE, WR, RD1, RD2 and CLR; ready SHALL be 1 only in IDLE.
REQ-019 In IDLE with clr_start=1, the controller SHALL enter CLR, ignoring req in the same cycle (clr_start has priority).
REQ-020 In IDLE with req=1 and addr[1:0]!=0, the controller SHALL pulse err for one cycle, make no RAM access and stay in IDLE.
REQ-021 Write accepted at edge E0: ram_wea<=1, ram_addr<=addr[7:2], ram_dina<=wdata, state<=WR; at E1: ram_wea<=0, state<=IDLE; ready returns 1 one cycle after acceptance.
REQ-022 Read accepted at E0: ram_addr<=addr[7:2], ram_wea stays 0, state<=RD1; at E1 state<=RD2; at E2 rdata<=ram_douta, rvalid<=1, state<=IDLE.
REQ-023 rvalid SHALL rise two cycles after read acceptance and fall the following cycle; rdata SHALL be unchanged except at that capture.
REQ-024 CLR: a 6-bit counter starts at 0; each cycle ram_wea=1, ram_addr=counter, ram_dina=CLR_VAL; the counter increments each cycle.
REQ-025 After word 63 is written, ram_wea<=0, clr_done pulses for one cycle, and state<=IDLE; the sweep lasts exactly 64 write cycles.
REQ-026 The counter SHALL NOT wrap into a second sweep; clr_start and req asserted during CLR, WR, RD1 or RD2 SHALL be ignored and not queued.
REQ-027 Back-to-back requests SHALL be legal; a req held high is accepted again in the first IDLE cycle.
REQ-028 ram_wea SHALL never be 1 outside WR and CLR.

Reset
REQ-029 On rst=1 at an edge: state<=IDLE, ready=1, ram_wea=0, ram_addr=0, ram_dina=0, rdata=0, rvalid=0, err=0, clr_done=0, and the counter is cleared to 0.
REQ-030 rst SHALL abort any operation in progress (including mid-CLR) with no further RAM write and no rvalid or clr_done pulse.

Verification
REQ-031 Write 0xDEADBEEF to addr 0x14, then read addr 0x14: ram_addr=5 and ram_wea high for exactly one cycle; rvalid two cycles after read acceptance with rdata=0xDEADBEEF.
REQ-032 req with addr=0x06: err pulses once, ram_wea stays 0, ready stays 1.
REQ-033 clr_start after writing 0x12345678 to addr 0xFC: exactly 64 ram_wea cycles on addresses 0..63, clr_done pulses once, and a read of 0xFC returns 0x00000000.
REQ-034 clr_start and req asserted in the same IDLE cycle: CLR is entered, and the req is not serviced until it is reasserted in IDLE.
REQ-035 rst asserted at counter=20 during CLR: the next cycle has ram_wea=0 and ready=1, and no clr_done pulse occurs.
REQ-036 req held high with reads of 0x00 and 0x04 alternating: each read is accepted in its own IDLE cycle, and the rvalid pulses are 3 cycles apart.
